// File: rtl/io_arb_pkg.sv
// Shared constants for the IO bus arbiter: state encoding, parameter defaults
// and the read-timeout error word.
package io_arb_pkg;

   localparam int N_REQ_DEF       = 4;
   localparam int AW_DEF          = 16;
   localparam int DW_DEF          = 32;
   localparam int HOLD_CYCLES_DEF = 3;
   localparam int TIMEOUT_DEF     = 255;

   localparam int IDX_IDLE      = 0;
   localparam int IDX_WRITE_EN  = 1;
   localparam int IDX_READ_WAIT = 2;
   localparam int IDX_ACK       = 3;
   localparam int IDX_HOLD      = 4;

   typedef enum logic [4:0] {
      ST_IDLE      = 5'b00001,
      ST_WRITE_EN  = 5'b00010,
      ST_READ_WAIT = 5'b00100,
      ST_ACK       = 5'b01000,
      ST_HOLD      = 5'b10000
   } state_t;

   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

   // Index width that stays legal for a single requester.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: scans upward from last+1 with wrap and
// reports the first active requester.
module rr_arbiter
   import io_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IDW   = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   last,
   output logic [IDW-1:0]   grant,
   output logic             valid
);

   logic [IDW-1:0] grant_s;
   logic           valid_s;

   // Walk the ring farthest-first so the nearest requester after last wins.
   always_comb begin
      grant_s = {IDW{1'b0}};
      valid_s = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         valid_s = valid_s | req[(int'(last) + k) % N_REQ];
         grant_s = req[(int'(last) + k) % N_REQ] ? IDW'((int'(last) + k) % N_REQ) : grant_s;
      end
   end

   assign grant = grant_s;
   assign valid = valid_s;

endmodule

// File: rtl/io_bus_arbiter.sv
// Multi-requester arbiter onto a single IO bus with write strobe / read handshake.
// Optional read timeout is enabled by defining IO_ARB_TIMEOUT_EN.
module io_bus_arbiter
   import io_arb_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int AW          = AW_DEF,
   parameter int DW          = DW_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic                       clk,
   input  logic                       res,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           wr,
   input  logic [N_REQ*AW-1:0]        addr,
   input  logic [N_REQ*DW-1:0]        wdata,
   output logic [N_REQ-1:0]           ack,
   output logic [N_REQ-1:0]           err,
   output logic [DW-1:0]              rdata,
   output logic [AW-1:0]              io_addr,
   output logic [DW-1:0]              io_wdata,
   output logic                       io_wr_en,
   output logic                       io_rd_en,
   output logic                       io_sync,
   input  logic                       io_rd_ack,
   input  logic [DW-1:0]              io_rdata,
   output logic [id_width(N_REQ)-1:0] grant_id,
   output logic [5:0]                 state_peek
);

   localparam int IDW = id_width(N_REQ);
   localparam int HCW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? HCW'(HOLD_CYCLES - 1) : {HCW{1'b0}};
   localparam logic [DW-1:0]  ERR_DW    = DW'(ERR_WORD);

   state_t           state_r, state_nxt_s;
   logic [IDW-1:0]   last_r, gid_r, arb_grant_s;
   logic             arb_valid_s, grant_take_s, sel_wr_s, wr_lat_r;
   logic [HCW-1:0]   hold_cnt_r;
   logic             hold_done_s, to_hit_s, err_set_s;
   logic [N_REQ-1:0] ack_r;
   logic [DW-1:0]    rdata_r, io_wdata_r;
   logic [AW-1:0]    io_addr_r;
   logic             io_wr_en_r, io_rd_en_r, io_sync_r;
   logic [5:0]       state_peek_r;

   function automatic logic [N_REQ-1:0] id_onehot(input logic [IDW-1:0] id);
      logic [N_REQ-1:0] v;
      v     = {N_REQ{1'b0}};
      v[id] = 1'b1;
      return v;
   endfunction

   rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_rr (
      .req   (req),
      .last  (last_r),
      .grant (arb_grant_s),
      .valid (arb_valid_s)
   );

   assign grant_take_s = (state_r == ST_IDLE) && arb_valid_s;
   assign sel_wr_s     = wr[arb_grant_s];
   assign hold_done_s  = (hold_cnt_r == HOLD_LAST);
   assign err_set_s    = (state_r == ST_READ_WAIT) && to_hit_s && !io_rd_ack;

`ifdef IO_ARB_TIMEOUT_EN
   localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TCW-1:0] to_cnt_r;
   logic [N_REQ-1:0] err_r;

   assign to_hit_s = (to_cnt_r == TCW'(TIMEOUT - 1));

   // Read-wait cycle counter; held at zero outside READ_WAIT so every read starts fresh.
   always_ff @(posedge clk) begin
      if (res) begin
         to_cnt_r <= {TCW{1'b0}};
         err_r    <= {N_REQ{1'b0}};
      end else begin
         to_cnt_r <= (state_r == ST_READ_WAIT) ? to_cnt_r + TCW'(1) : {TCW{1'b0}};
         err_r    <= err_set_s ? id_onehot(gid_r) : {N_REQ{1'b0}};
      end
   end

   assign err = err_r;
`else
   assign to_hit_s = 1'b0;
   assign err      = {N_REQ{1'b0}};
`endif

   // Next-state decode for the one-hot transaction FSM.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (arb_valid_s) begin
               state_nxt_s = sel_wr_s ? ST_WRITE_EN : ST_READ_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE_EN: state_nxt_s = ST_ACK;
         ST_READ_WAIT: begin
            if (io_rd_ack || to_hit_s) begin
               state_nxt_s = ST_ACK;
            end else begin
               state_nxt_s = ST_READ_WAIT;
            end
         end
         ST_ACK: begin
            if (HOLD_CYCLES == 0) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_done_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, grant latch and outputs registered from the next-state decode.
   always_ff @(posedge clk) begin
      if (res) begin
         state_r      <= ST_IDLE;
         last_r       <= IDW'(N_REQ - 1);
         gid_r        <= {IDW{1'b0}};
         wr_lat_r     <= 1'b0;
         hold_cnt_r   <= {HCW{1'b0}};
         ack_r        <= {N_REQ{1'b0}};
         rdata_r      <= {DW{1'b0}};
         io_addr_r    <= {AW{1'b0}};
         io_wdata_r   <= {DW{1'b0}};
         io_wr_en_r   <= 1'b0;
         io_rd_en_r   <= 1'b0;
         io_sync_r    <= 1'b0;
         state_peek_r <= 6'b000000;
      end else begin
         state_r <= state_nxt_s;
         if (grant_take_s) begin
            gid_r      <= arb_grant_s;
            last_r     <= arb_grant_s;
            wr_lat_r   <= sel_wr_s;
            io_addr_r  <= addr[arb_grant_s*AW +: AW];
            io_wdata_r <= wdata[arb_grant_s*DW +: DW];
         end
         hold_cnt_r <= (state_r == ST_HOLD) ? hold_cnt_r + HCW'(1) : {HCW{1'b0}};
         ack_r      <= (state_nxt_s == ST_ACK) ? id_onehot(gid_r) : {N_REQ{1'b0}};
         if ((state_r == ST_READ_WAIT) && io_rd_ack) begin
            rdata_r <= io_rdata;
         end else if (err_set_s) begin
            rdata_r <= ERR_DW;
         end
         io_wr_en_r   <= (state_nxt_s == ST_WRITE_EN);
         // Read enable stays up through ACK and HOLD of a read.
         io_rd_en_r   <= (state_nxt_s == ST_READ_WAIT) ||
                         (((state_nxt_s == ST_ACK) || (state_nxt_s == ST_HOLD)) && !wr_lat_r);
         io_sync_r    <= (state_nxt_s != ST_IDLE);
         state_peek_r <= {1'b0, state_nxt_s};
      end
   end

   assign ack        = ack_r;
   assign rdata      = rdata_r;
   assign io_addr    = io_addr_r;
   assign io_wdata   = io_wdata_r;
   assign io_wr_en   = io_wr_en_r;
   assign io_rd_en   = io_rd_en_r;
   assign io_sync    = io_sync_r;
   assign grant_id   = gid_r;
   assign state_peek = state_peek_r;

endmodule
